// File: rtl/fc_snapshot_pkg.sv
// Shared constants for the frequency-counter snapshot queue: register map,
// STATUS bit layout and field widths.
package fc_snapshot_pkg;

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_REF_SYS = 8'h04;
  localparam logic [7:0] OFF_SIG     = 8'h08;
  localparam logic [7:0] OFF_SIG_SYS = 8'h0C;
  localparam logic [7:0] OFF_EPOCH   = 8'h10;
  localparam logic [7:0] OFF_CTRL    = 8'h14;
  localparam logic [7:0] OFF_TSTAMP  = 8'h18;

  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_DROP_LSB  = 16;

  localparam int EPOCH_BITS = 8;
  localparam int DROP_BITS  = 8;

  function automatic logic [31:0] pack_status(input logic [4:0] count, input logic empty,
                                              input logic full, input logic ovf,
                                              input logic [DROP_BITS-1:0] drop);
    logic [31:0] s;
    s = 32'd0;
    s[4:0] = count;
    s[ST_EMPTY_BIT] = empty;
    s[ST_FULL_BIT] = full;
    s[ST_OVF_BIT] = ovf;
    s[ST_DROP_LSB +: DROP_BITS] = drop;
    return s;
  endfunction

endpackage

// File: rtl/fc_snapshot_fifo.sv
// Synchronous FIFO with flush; a push is accepted while full when a pop
// retires the head in the same cycle, and a pop on empty is ignored.
module fc_snapshot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 104
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [4:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == 5'(DEPTH));
  assign empty     = (count_r == 5'd0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 5'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/fc_snapshot_queue.sv
// Snapshot queue between the frequency counter and the picosoc iomem bus.
// Optional macro FC_QUEUE_TIMESTAMP_EN adds a per-entry cycle timestamp at 0x18.
module fc_snapshot_queue
  import fc_snapshot_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          CNT_BITS  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_pulse,
  input  logic [CNT_BITS-1:0] ref_sys_cnt,
  input  logic [CNT_BITS-1:0] sig_cnt,
  input  logic [CNT_BITS-1:0] sig_sys_cnt,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  output logic                irq
);

  localparam int DATA_BITS = 3 * CNT_BITS + EPOCH_BITS;
`ifdef FC_QUEUE_TIMESTAMP_EN
  localparam int ENTRY_BITS = DATA_BITS + 32;
`else
  localparam int ENTRY_BITS = DATA_BITS;
`endif

  logic                  enable_r;
  logic                  overflow_r;
  logic [DROP_BITS-1:0]  drop_cnt_r;
  logic [EPOCH_BITS-1:0] epoch_r;
  logic [EPOCH_BITS-1:0] epoch_next_s;
  logic                  dec_s, wr_s, clear_s, pop_s, cap_s, drop_s, ctrl_wr_s;
  logic [7:0]            off_s;
  logic [4:0]            count_s;
  logic                  full_s, empty_s;
  logic [ENTRY_BITS-1:0] din_s, head_s, head_m_s;
  logic [31:0]           rd_s;
  logic                  unused_bits;

  assign off_s        = iomem_addr[7:0];
  assign dec_s        = iomem_valid && !iomem_ready && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign wr_s         = dec_s && (iomem_wstrb != 4'd0);
  assign ctrl_wr_s    = wr_s && (off_s == OFF_CTRL);
  assign clear_s      = ctrl_wr_s && iomem_wdata[1];
  assign pop_s        = wr_s && (off_s == OFF_EPOCH);
  assign cap_s        = cap_pulse && enable_r && !clear_s;
  // A pop on a full FIFO always succeeds, so it makes room for the capture.
  assign drop_s       = cap_s && full_s && !pop_s;
  assign epoch_next_s = epoch_r + 8'd1;
  assign head_m_s     = empty_s ? '0 : head_s;
  assign unused_bits  = &{1'b0, iomem_wdata[31:2]};

`ifdef FC_QUEUE_TIMESTAMP_EN
  logic [31:0] tstamp_r;

  // Free-running cycle counter sampled into each captured entry.
  always_ff @(posedge clk) begin
    if (reset) tstamp_r <= 32'd0;
    else       tstamp_r <= tstamp_r + 32'd1;
  end

  assign din_s = {tstamp_r, epoch_next_s, sig_sys_cnt, sig_cnt, ref_sys_cnt};
`else
  assign din_s = {epoch_next_s, sig_sys_cnt, sig_cnt, ref_sys_cnt};
`endif

  fc_snapshot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear_s),
    .push  (cap_s),
    .pop   (pop_s),
    .din   (din_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Register read mux; head fields are zero-extended and read 0 when empty.
  always_comb begin
    rd_s = 32'd0;
    case (off_s)
      OFF_STATUS:  rd_s = pack_status(count_s, empty_s, full_s, overflow_r, drop_cnt_r);
      OFF_REF_SYS: rd_s = 32'(head_m_s[CNT_BITS-1:0]);
      OFF_SIG:     rd_s = 32'(head_m_s[2*CNT_BITS-1:CNT_BITS]);
      OFF_SIG_SYS: rd_s = 32'(head_m_s[3*CNT_BITS-1:2*CNT_BITS]);
      OFF_EPOCH:   rd_s = 32'(head_m_s[DATA_BITS-1:3*CNT_BITS]);
      OFF_CTRL:    rd_s = {31'd0, enable_r};
`ifdef FC_QUEUE_TIMESTAMP_EN
      OFF_TSTAMP:  rd_s = head_m_s[ENTRY_BITS-1:DATA_BITS];
`endif
      default:     rd_s = 32'd0;
    endcase
  end

  // Control, epoch and drop accounting; clear wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r   <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
      epoch_r    <= 8'd0;
    end else if (clear_s) begin
      enable_r   <= iomem_wdata[0];
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
      epoch_r    <= 8'd0;
    end else begin
      if (ctrl_wr_s) enable_r <= iomem_wdata[0];
      if (cap_s) epoch_r <= epoch_next_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  // Bus response and interrupt level.
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
      irq         <= 1'b0;
    end else begin
      iomem_ready <= dec_s;
      if (dec_s) iomem_rdata <= rd_s;
      irq <= enable_r && !empty_s;
    end
  end

endmodule

// File: tb/tb_fc_snapshot_queue.sv
// Directed, table-driven bench for fc_snapshot_queue (default build, DEPTH=4).
module tb_fc_snapshot_queue;

  localparam logic [31:0] BASE = 32'h0300_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap_pulse = 1'b0;
  logic [31:0] ref_sys_cnt = 32'd0, sig_cnt = 32'd0, sig_sys_cnt = 32'd0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_addr = 32'd0, iomem_wdata = 32'd0, iomem_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 capture only, 1 read, 2 write
    logic [7:0]  off;
    logic [31:0] wd;
    logic        cap;
    logic [31:0] r, s, ss;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  fc_snapshot_queue dut (
    .clk(clk), .reset(reset), .cap_pulse(cap_pulse),
    .ref_sys_cnt(ref_sys_cnt), .sig_cnt(sig_cnt), .sig_sys_cnt(sig_sys_cnt),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void v_rd(input logic [7:0] off, input logic [31:0] exp);
    vec_t v;
    v.kind = 1; v.off = off; v.wd = 32'd0; v.cap = 1'b0;
    v.r = 32'd0; v.s = 32'd0; v.ss = 32'd0; v.exp = exp;
    tbl.push_back(v);
  endfunction

  function automatic void v_wr(input logic [7:0] off, input logic [31:0] wd, input logic cap,
                               input logic [31:0] r, input logic [31:0] s, input logic [31:0] ss);
    vec_t v;
    v.kind = 2; v.off = off; v.wd = wd; v.cap = cap;
    v.r = r; v.s = s; v.ss = ss; v.exp = 32'd0;
    tbl.push_back(v);
  endfunction

  function automatic void v_cp(input logic [31:0] r, input logic [31:0] s, input logic [31:0] ss);
    vec_t v;
    v.kind = 0; v.off = 8'h00; v.wd = 32'd0; v.cap = 1'b1;
    v.r = r; v.s = s; v.ss = ss; v.exp = 32'd0;
    tbl.push_back(v);
  endfunction

  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                     input logic cap, input logic [31:0] r, input logic [31:0] s,
                     input logic [31:0] ss, output logic [31:0] rd);
    logic ok;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb; iomem_wdata = wdata;
    cap_pulse = cap; ref_sys_cnt = r; sig_cnt = s; sig_sys_cnt = ss;
    ok = 1'b0; rd = 32'd0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      cap_pulse = 1'b0;
      if (iomem_ready) begin
        ok = 1'b1;
        rd = iomem_rdata;
      end
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    check($sformatf("bus_ready_%h", addr), {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse(input logic [31:0] r, input logic [31:0] s, input logic [31:0] ss);
    @(negedge clk);
    cap_pulse = 1'b1; ref_sys_cnt = r; sig_cnt = s; sig_sys_cnt = ss;
    @(negedge clk);
    cap_pulse = 1'b0;
  endtask

  task automatic run_table();
    logic [31:0] rd;
    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].kind)
        0: pulse(tbl[i].r, tbl[i].s, tbl[i].ss);
        1: begin
          bus(BASE | {24'd0, tbl[i].off}, 4'h0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rd);
          check($sformatf("vec%0d_off%h", i, tbl[i].off), rd, tbl[i].exp);
        end
        default: bus(BASE | {24'd0, tbl[i].off}, 4'hF, tbl[i].wd, tbl[i].cap,
                     tbl[i].r, tbl[i].s, tbl[i].ss, rd);
      endcase
    end
    tbl.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_ready", {31'd0, iomem_ready}, 32'd0);
    check("reset_rdata", iomem_rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus(BASE | 32'h00, 4'h0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rd);
    check("reset_status", rd, 32'h0000_0100);
    bus(BASE | 32'h14, 4'h0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rd);
    check("reset_ctrl", rd, 32'd0);

    // Enable, then the first capture; irq follows one cycle after the push.
    bus(BASE | 32'h14, 4'hF, 32'd1, 1'b0, 32'd0, 32'd0, 32'd0, rd);
    check("irq_enabled_empty", {31'd0, irq}, 32'd0);
    @(negedge clk);
    cap_pulse = 1'b1; ref_sys_cnt = 32'd100; sig_cnt = 32'd200; sig_sys_cnt = 32'd300;
    @(negedge clk);
    cap_pulse = 1'b0;
    check("irq_same_cycle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_next_cycle", {31'd0, irq}, 32'd1);

    v_rd(8'h00, 32'h0000_0001);
    v_rd(8'h04, 32'd100); v_rd(8'h08, 32'd200); v_rd(8'h0C, 32'd300); v_rd(8'h10, 32'd1);
    v_cp(32'd11, 32'd21, 32'd31); v_cp(32'd12, 32'd22, 32'd32);
    v_cp(32'd13, 32'd23, 32'd33); v_cp(32'd14, 32'd24, 32'd34);
    v_rd(8'h00, 32'h0001_0604);
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h10, 32'd2); v_rd(8'h04, 32'd11);
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h10, 32'd3);
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h10, 32'd4); v_rd(8'h0C, 32'd33);
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h00, 32'h0001_0500); v_rd(8'h10, 32'd0); v_rd(8'h08, 32'd0);
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h00, 32'h0001_0500);
    run_table();
    check("irq_after_drain", {31'd0, irq}, 32'd0);

    // Clear+enable, fill, then pop and capture together while full.
    v_wr(8'h14, 32'd3, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h00, 32'h0000_0100);
    for (int i = 1; i <= 4; i++) v_cp(32'(40 + i), 32'd0, 32'd0);
    v_rd(8'h00, 32'h0000_0204);
    v_wr(8'h10, 32'd0, 1'b1, 32'd77, 32'd78, 32'd79);
    v_rd(8'h00, 32'h0000_0204); v_rd(8'h10, 32'd2);
    for (int i = 0; i < 3; i++) v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h10, 32'd5); v_rd(8'h04, 32'd77); v_rd(8'h08, 32'd78); v_rd(8'h00, 32'h0000_0001);
    // Pop and capture together while empty: capture wins, pop ignored.
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_wr(8'h10, 32'd0, 1'b1, 32'd90, 32'd91, 32'd92);
    v_rd(8'h00, 32'h0000_0001); v_rd(8'h10, 32'd6); v_rd(8'h04, 32'd90);
    // 300 captures: drop count saturates, epoch wraps to 44.
    v_wr(8'h14, 32'd3, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 300; i++) v_cp(32'(i), 32'(i + 1000), 32'(i + 2000));
    v_rd(8'h00, 32'h00FF_0604); v_rd(8'h10, 32'd1); v_rd(8'h04, 32'd0);
    for (int i = 0; i < 4; i++) v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_cp(32'd500, 32'd501, 32'd502);
    v_rd(8'h10, 32'd45); v_rd(8'h00, 32'h00FF_0401);
    // Clear coincident with a capture discards it.
    v_wr(8'h14, 32'd3, 1'b1, 32'd66, 32'd67, 32'd68);
    v_rd(8'h14, 32'd1); v_rd(8'h00, 32'h0000_0100); v_rd(8'h10, 32'd0);
    v_cp(32'd60, 32'd0, 32'd0);
    v_rd(8'h10, 32'd1); v_rd(8'h04, 32'd60); v_rd(8'h00, 32'h0000_0001);
    // Disabled: captures ignored entirely, queued data stays readable.
    v_wr(8'h14, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_cp(32'd61, 32'd0, 32'd0);
    v_rd(8'h00, 32'h0000_0001); v_rd(8'h04, 32'd60); v_rd(8'h14, 32'd0);
    v_wr(8'h14, 32'd1, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h14, 32'd1);
    v_cp(32'd62, 32'd0, 32'd0);
    v_rd(8'h00, 32'h0000_0002);
    v_wr(8'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    v_rd(8'h10, 32'd2); v_rd(8'h04, 32'd62);
    v_rd(8'h20, 32'd0);
`ifndef FC_QUEUE_TIMESTAMP_EN
    v_rd(8'h18, 32'd0);
`endif
    run_table();
    check("irq_nonempty", {31'd0, irq}, 32'd1);

    // Request outside the window: no ack and no pop.
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0210; iomem_wstrb = 4'hF; iomem_wdata = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (iomem_ready) seen = 1'b1;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    check("unmatched_ready", {31'd0, seen}, 32'd0);
    bus(BASE | 32'h00, 4'h0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rd);
    check("unmatched_status", rd, 32'h0000_0001);

    // Reset while ready is high.
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'h0;
    @(negedge clk);
    check("pre_reset_ready", {31'd0, iomem_ready}, 32'd1);
    reset = 1'b1; iomem_valid = 1'b0;
    @(negedge clk);
    check("mid_reset_ready", {31'd0, iomem_ready}, 32'd0);
    check("mid_reset_rdata", iomem_rdata, 32'd0);
    reset = 1'b0;
    bus(BASE | 32'h00, 4'h0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rd);
    check("post_reset_status", rd, 32'h0000_0100);
    bus(BASE | 32'h14, 4'h0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rd);
    check("post_reset_ctrl", rd, 32'd0);
    check("post_reset_irq", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
